// File: rtl/hcp_pkg.sv
// Shared HCP definitions: frame delimiters and receive-channel state encoding.
package hcp_pkg;

    localparam logic [7:0] START_FRAME = 8'h7E;
    localparam logic [7:0] STOP_FRAME  = 8'hFE;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } chan_state_t;

endpackage

// File: rtl/hcp_slave_rx_if.sv
// Bus-side and core-side signals of the HCP slave receiver, grouped for port connection.
interface hcp_slave_rx_if;

    logic       bus_clk;
    logic       sbda;
    logic       rx_en;

    logic [7:0] r_data;
    logic       r_valid;
    logic       r_sof;
    logic       r_eof;
    logic       r_err;
    logic       r_busy;

    logic [7:0] f_data;
    logic       f_valid;
    logic       f_sof;
    logic       f_eof;
    logic       f_err;
    logic       f_busy;

    modport master (
        output bus_clk, sbda, rx_en,
        input  r_data, r_valid, r_sof, r_eof, r_err, r_busy,
        input  f_data, f_valid, f_sof, f_eof, f_err, f_busy
    );

    modport slave (
        input  bus_clk, sbda, rx_en,
        output r_data, r_valid, r_sof, r_eof, r_err, r_busy,
        output f_data, f_valid, f_sof, f_eof, f_err, f_busy
    );

endinterface

// File: rtl/hcp_rx_channel.sv
// One HCP receive channel: start-frame hunt, LSB-first deserialiser, stop detect and stall timeout.
module hcp_rx_channel
    import hcp_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       stb,
    input  logic       sda,
    output logic [7:0] data,
    output logic       valid,
    output logic       sof,
    output logic       eof,
    output logic       err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    chan_state_t state, state_n;
    logic [7:0]  sh, sh_n, data_n;
    logic [2:0]  bitcnt, bitcnt_n;
    logic [TW-1:0] tmr, tmr_n;
    logic        valid_n, sof_n, eof_n, err_n;
    logic [7:0]  sh_shift;

    assign sh_shift = {sda, sh[7:1]};
    assign busy     = (state == RECV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= HUNT;
            sh     <= '0;
            bitcnt <= '0;
            tmr    <= '0;
            data   <= '0;
            valid  <= 1'b0;
            sof    <= 1'b0;
            eof    <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            sh     <= sh_n;
            bitcnt <= bitcnt_n;
            tmr    <= tmr_n;
            data   <= data_n;
            valid  <= valid_n;
            sof    <= sof_n;
            eof    <= eof_n;
            err    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        sh_n     = sh;
        bitcnt_n = bitcnt;
        tmr_n    = tmr;
        data_n   = data;
        valid_n  = 1'b0;
        sof_n    = 1'b0;
        eof_n    = 1'b0;
        err_n    = 1'b0;

        if (!en) begin
            // Disabling is a silent abort: no err/eof reported to the core.
            state_n  = HUNT;
            sh_n     = '0;
            bitcnt_n = '0;
            tmr_n    = '0;
        end else begin
            case (state)
                HUNT: begin
                    tmr_n = '0;
                    if (stb) begin
                        sh_n = sh_shift;
                        if (sh_shift == START_FRAME) begin
                            state_n  = RECV;
                            sof_n    = 1'b1;
                            bitcnt_n = '0;
                        end
                    end
                end
                RECV: begin
                    if (stb) begin
                        sh_n     = sh_shift;
                        bitcnt_n = bitcnt + 3'd1;
                        tmr_n    = '0;
                        if (bitcnt == 3'd7) begin
                            if (sh_shift == STOP_FRAME) begin
                                eof_n   = 1'b1;
                                state_n = HUNT;
                                sh_n    = '0;
                            end else if (sh_shift == START_FRAME) begin
                                err_n = 1'b1;
                                sof_n = 1'b1;
                            end else begin
                                data_n  = sh_shift;
                                valid_n = 1'b1;
                            end
                        end
                    end else if (tmr == TW'(TIMEOUT_CYC - 1)) begin
                        // Bus clock stalled mid-frame: drop the partial octet.
                        err_n    = 1'b1;
                        state_n  = HUNT;
                        sh_n     = '0;
                        bitcnt_n = '0;
                        tmr_n    = '0;
                    end else begin
                        tmr_n = tmr + TW'(1);
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

endmodule

// File: rtl/hcp_slave_rx.sv
// HCP slave receive front-end: synchronises bus_clk/sbda, derives per-channel strobes, runs two channels.
module hcp_slave_rx
    import hcp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic     clk,
    input  logic     rst,
    hcp_slave_rx_if.slave bus
);

    localparam int SW = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0] bclk_sync, sda_sync;
    logic                   bclk_d;
    logic [SW-1:0]          supp;
    logic                   bclk_s, sda_s, edge_ok;
    logic                   r_stb, f_stb;

    assign bclk_s  = bclk_sync[SYNC_STAGES-1];
    assign sda_s   = sda_sync[SYNC_STAGES-1];
    assign edge_ok = (supp == '0);
    assign r_stb   = edge_ok &  bclk_d & ~bclk_s;
    assign f_stb   = edge_ok & ~bclk_d &  bclk_s;

    // Both lines share one chain depth so data stays aligned with its clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync <= '0;
            sda_sync  <= '0;
            bclk_d    <= 1'b0;
            supp      <= SW'(SYNC_STAGES + 1);
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bus.bus_clk};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], bus.sbda};
            bclk_d    <= bclk_s;
            // Hold off strobes until the cleared chain has refilled with the live level.
            if (supp != '0) supp <= supp - SW'(1);
        end
    end

    hcp_rx_channel #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rise (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.rx_en),
        .stb   (r_stb),
        .sda   (sda_s),
        .data  (bus.r_data),
        .valid (bus.r_valid),
        .sof   (bus.r_sof),
        .eof   (bus.r_eof),
        .err   (bus.r_err),
        .busy  (bus.r_busy)
    );

    hcp_rx_channel #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_fall (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.rx_en),
        .stb   (f_stb),
        .sda   (sda_s),
        .data  (bus.f_data),
        .valid (bus.f_valid),
        .sof   (bus.f_sof),
        .eof   (bus.f_eof),
        .err   (bus.f_err),
        .busy  (bus.f_busy)
    );

endmodule

// File: tb/tb_hcp_slave_rx.sv
// Directed bench for hcp_slave_rx: frame-level event model per channel plus literal spot values.
module tb_hcp_slave_rx;

    localparam int SYNC = 2;
    localparam int TO   = 1024;
    localparam int EV_SOF = 1, EV_VAL = 2, EV_EOF = 3, EV_ERRSOF = 4, EV_ERR = 5, EV_BAD = 99;

    logic clk = 1'b0;
    logic rst;
    hcp_slave_rx_if hif ();

    hcp_slave_rx #(.SYNC_STAGES(SYNC), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rv_cnt = 0, fv_cnt = 0, r_err_cnt = 0, r_err_cyc = 0;
    int   last_fall_cyc = 0;
    int   rq[$];
    int   fq[$];
    logic rbits[$];
    logic fbits[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int enc(input logic v, input logic s, input logic e, input logic er,
                               input logic [7:0] d);
        if (v && !s && !e && !er) return EV_VAL * 256 + int'(d);
        if (!v && s && er && !e)  return EV_ERRSOF * 256;
        if (!v && s && !e && !er) return EV_SOF * 256;
        if (!v && e && !s && !er) return EV_EOF * 256;
        if (!v && er && !s && !e) return EV_ERR * 256;
        return EV_BAD * 256;
    endfunction

    task automatic observe(input int obs, input bit is_f);
        int exp;
        if (is_f) begin
            if (fq.size() == 0) exp = -1; else exp = fq.pop_front();
        end else begin
            if (rq.size() == 0) exp = -1; else exp = rq.pop_front();
        end
        check(is_f ? "f_event" : "r_event", obs, exp);
    endtask

    // Compare process: every pulse on either channel must be the next modelled event.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (!rst) begin
            if (hif.r_valid | hif.r_sof | hif.r_eof | hif.r_err) begin
                observe(enc(hif.r_valid, hif.r_sof, hif.r_eof, hif.r_err, hif.r_data), 1'b0);
                if (hif.r_valid) rv_cnt++;
                if (hif.r_err) begin
                    r_err_cnt++;
                    r_err_cyc = cyc;
                end
            end
            if (hif.f_valid | hif.f_sof | hif.f_eof | hif.f_err) begin
                observe(enc(hif.f_valid, hif.f_sof, hif.f_eof, hif.f_err, hif.f_data), 1'b1);
                if (hif.f_valid) fv_cnt++;
            end
        end
    end

    // Frame parser over the transmitted bit stream: hunt at any alignment, then whole octets.
    task automatic model_chan(input bit is_f);
        logic       bits[$];
        logic [7:0] win = 8'h00;
        logic [7:0] oct = 8'h00;
        bit         inframe = 0;
        int         n = 0;
        int         ev[$];
        if (is_f) bits = fbits; else bits = rbits;
        foreach (bits[i]) begin
            if (!inframe) begin
                win = {bits[i], win[7:1]};
                if (win == 8'h7E) begin
                    ev.push_back(EV_SOF * 256);
                    inframe = 1;
                    n = 0;
                end
            end else begin
                oct = {bits[i], oct[7:1]};
                n++;
                if (n == 8) begin
                    n = 0;
                    if (oct == 8'hFE) begin
                        ev.push_back(EV_EOF * 256);
                        inframe = 0;
                        win = 8'h00;
                    end else if (oct == 8'h7E) begin
                        ev.push_back(EV_ERRSOF * 256);
                    end else begin
                        ev.push_back(EV_VAL * 256 + int'(oct));
                    end
                end
            end
        end
        foreach (ev[i]) begin
            if (is_f) fq.push_back(ev[i]); else rq.push_back(ev[i]);
        end
    endtask

    task automatic rbyte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) rbits.push_back(b[i]);
    endtask

    task automatic fbyte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) fbits.push_back(b[i]);
    endtask

    // One bus_clk period (16 clk): data changes two clk after each bus edge.
    task automatic bus_cycle(input logic rb, input logic fb);
        @(negedge clk) hif.bus_clk = 1'b1;
        repeat (2) @(negedge clk);
        hif.sbda = rb;
        repeat (6) @(negedge clk);
        hif.bus_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (2) @(negedge clk);
        hif.sbda = fb;
        repeat (5) @(negedge clk);
    endtask

    task automatic send(input bit use_model);
        int n;
        if (use_model) begin
            model_chan(1'b0);
            model_chan(1'b1);
        end
        n = rbits.size();
        if (fbits.size() + 1 > n) n = fbits.size() + 1;
        for (int i = 0; i < n; i++)
            bus_cycle(i < rbits.size() ? rbits[i] : 1'b0, i < fbits.size() ? fbits[i] : 1'b0);
        rbits.delete();
        fbits.delete();
        repeat (8) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {hif.r_data, hif.r_valid, hif.r_sof, hif.r_eof, hif.r_err, hif.r_busy,
                     hif.f_data, hif.f_valid, hif.f_sof, hif.f_eof, hif.f_err, hif.f_busy}, 32'h0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_rq_left"}, rq.size(), 0);
        check({tag, "_fq_left"}, fq.size(), 0);
        check({tag, "_r_busy"}, hif.r_busy, 1'b0);
        check({tag, "_f_busy"}, hif.f_busy, 1'b0);
    endtask

    initial begin
        int rv0, fv0, e0, k;
        rst = 1'b1;
        hif.bus_clk = 1'b0;
        hif.sbda    = 1'b0;
        hif.rx_en   = 1'b1;
        repeat (5) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_all_zero("idle_after_reset");

        // Rising-only frame
        rv0 = rv_cnt; fv0 = fv_cnt;
        rbyte(8'h7E); rbyte(8'hA5); rbyte(8'h3C); rbyte(8'hFE);
        send(1);
        check("t1_r_data", hif.r_data, 8'h3C);
        check("t1_r_valids", rv_cnt - rv0, 2);
        check("t1_f_data", hif.f_data, 8'h00);
        check("t1_f_valids", fv_cnt - fv0, 0);
        check_drained("t1");

        // Both channels concurrently
        rv0 = rv_cnt; fv0 = fv_cnt;
        rbyte(8'h7E); rbyte(8'h11); rbyte(8'hFE);
        fbyte(8'h7E); fbyte(8'h22); fbyte(8'h33); fbyte(8'hFE);
        send(1);
        check("t2_r_data", hif.r_data, 8'h11);
        check("t2_f_data", hif.f_data, 8'h33);
        check("t2_r_valids", rv_cnt - rv0, 1);
        check("t2_f_valids", fv_cnt - fv0, 2);
        check_drained("t2");

        // Misaligned start
        rv0 = rv_cnt;
        rbits.push_back(1'b1); rbits.push_back(1'b0); rbits.push_back(1'b1);
        rbyte(8'h7E); rbyte(8'h5A); rbyte(8'hFE);
        send(1);
        check("t3_r_data", hif.r_data, 8'h5A);
        check("t3_r_valids", rv_cnt - rv0, 1);
        check_drained("t3");

        // Stall timeout mid-byte
        rv0 = rv_cnt; e0 = r_err_cnt;
        rbyte(8'h7E);
        rbits.push_back(1'b1); rbits.push_back(1'b0); rbits.push_back(1'b1); rbits.push_back(1'b1);
        model_chan(1'b0);
        rq.push_back(EV_ERR * 256);
        send(0);
        check("t4_busy_in_stall", hif.r_busy, 1'b1);
        for (k = 0; k < 1500 && r_err_cnt == e0; k++) @(negedge clk);
        check("t4_err_seen", r_err_cnt - e0, 1);
        check("t4_err_delay", r_err_cyc - last_fall_cyc, TO + SYNC + 1);
        check("t4_no_valid", rv_cnt - rv0, 0);
        repeat (4) @(negedge clk);
        check_drained("t4");
        rbyte(8'h7E); rbyte(8'h99); rbyte(8'hFE);
        send(1);
        check("t4_after_data", hif.r_data, 8'h99);
        check_drained("t4b");

        // Start frame inside a frame resynchronises
        rv0 = rv_cnt;
        rbyte(8'h7E); rbyte(8'h12); rbyte(8'h7E); rbyte(8'h34); rbyte(8'hFE);
        model_chan(1'b0);
        check("t5_model_events", rq.size(), 5);
        send(0);
        check("t5_r_data", hif.r_data, 8'h34);
        check("t5_r_valids", rv_cnt - rv0, 2);
        check_drained("t5");

        // rx_en drop mid-frame: silent abort, strobes ignored while low
        rbyte(8'h7E); rbits.push_back(1'b1); rbits.push_back(1'b1); rbits.push_back(1'b0);
        send(1);
        check("t6_busy_before", hif.r_busy, 1'b1);
        hif.rx_en = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_busy_after", hif.r_busy, 1'b0);
        rbyte(8'h7E); rbyte(8'hA5);
        send(0);
        hif.rx_en = 1'b1;
        repeat (4) @(negedge clk);
        rbyte(8'h7E); rbyte(8'h66); rbyte(8'hFE);
        send(1);
        check("t6_r_data", hif.r_data, 8'h66);
        check_drained("t6");

        // Reset mid-frame with bus_clk high across release
        rbyte(8'h7E); rbits.push_back(1'b0); rbits.push_back(1'b1); rbits.push_back(1'b0);
        send(1);
        check("t7_busy_before", hif.r_busy, 1'b1);
        hif.bus_clk = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("t7_in_reset");
        rst = 1'b0;
        repeat (SYNC + 6) @(negedge clk);
        check_all_zero("t7_after_release");
        rbyte(8'h7E); rbyte(8'h77); rbyte(8'hFE);
        send(1);
        check("t7_r_data", hif.r_data, 8'h77);
        check_drained("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
